// File: rtl/qed_isa_pkg.sv
// Shared ISA constants, instruction-class and FSM enums for the instruction generator.
package qed_isa_pkg;

  localparam logic [6:0] OPC_OP_IMM         = 7'b0010011;
  localparam logic [6:0] OPC_LOAD           = 7'b0000011;
  localparam logic [6:0] OPC_OP             = 7'b0110011;
  localparam logic [6:0] OPC_STORE          = 7'b0100011;
  localparam logic [6:0] NOP_OPCODE_DEFAULT = 7'b1111111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h80200003;
  localparam logic [31:0] LFSR_RESET        = 32'h00000001;

  localparam int unsigned REG_LIMIT = 16;
  localparam int unsigned REG_IDX_W = $clog2(REG_LIMIT);

  typedef enum logic [2:0] {
    CLS_I   = 3'd0,
    CLS_LW  = 3'd1,
    CLS_R   = 3'd2,
    CLS_SW  = 3'd3,
    CLS_NOP = 3'd4
  } inst_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } gen_state_e;

  // Register fields only ever address the lower REG_LIMIT registers.
  function automatic logic [4:0] reg_field(input logic [REG_IDX_W-1:0] idx);
    return 5'(idx);
  endfunction

endpackage

// File: rtl/inst_gen_if.sv
// Control and instruction-stream signals of the instruction generator.
interface inst_gen_if;
  logic        start;
  logic [31:0] seed;
  logic [15:0] num_inst;
  logic [4:0]  class_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        busy;
  logic        done;

  modport master (
    input  start, seed, num_inst, class_en, out_ready,
    output out_valid, instruction, busy, done
  );

  modport slave (
    output start, seed, num_inst, class_en, out_ready,
    input  out_valid, instruction, busy, done
  );
endinterface

// File: rtl/inst_encode.sv
// Combinational mapping from LFSR state and enabled classes to a legal RV32 word.
module inst_encode
  import qed_isa_pkg::*;
#(
  parameter logic [6:0] NOP_OPCODE = NOP_OPCODE_DEFAULT
) (
  input  logic [31:0] lfsr,
  input  logic [4:0]  class_en,
  output logic [31:0] instruction
);

  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] f3;
  logic [6:0] imm_hi;
  logic [6:0] funct7;

  assign rd  = reg_field(lfsr[10:7]);
  assign rs1 = reg_field(lfsr[18:15]);
  assign rs2 = reg_field(lfsr[23:20]);
  assign f3  = lfsr[14:12];

  always_comb begin
    imm_hi      = lfsr[31:25];
    funct7      = F7_BASE;
    instruction = {25'b0, NOP_OPCODE};
    case (lfsr[2:0])
      CLS_I: if (class_en[0]) begin
        // Shift-immediates keep only a legal shamt and the SRAI select bit.
        if (f3 == F3_SLL)
          imm_hi = '0;
        else if (f3 == F3_SRL_SRA)
          imm_hi = {1'b0, lfsr[30], 5'b00000};
        instruction = {imm_hi, lfsr[24:20], rs1, f3, rd, OPC_OP_IMM};
      end
      CLS_LW: if (class_en[1]) begin
        instruction = {2'b00, lfsr[29:20], 5'b00000, F3_WORD, rd, OPC_LOAD};
      end
      CLS_R: if (class_en[2]) begin
        if ((f3 == F3_ADD_SUB || f3 == F3_SRL_SRA) && lfsr[30])
          funct7 = F7_ALT;
        instruction = {funct7, rs2, rs1, f3, rd, OPC_OP};
      end
      CLS_SW: if (class_en[3]) begin
        instruction = {2'b00, lfsr[29:25], rs2, 5'b00000, F3_WORD, lfsr[11:7], OPC_STORE};
      end
      default: instruction = {25'b0, NOP_OPCODE};
    endcase
  end

endmodule

// File: rtl/inst_gen.sv
// Constrained-random RV32 instruction generator: FSM, LFSR and emitted-count tracking.
module inst_gen
  import qed_isa_pkg::*;
#(
  parameter logic [6:0]  NOP_OPCODE = NOP_OPCODE_DEFAULT,
  parameter logic [31:0] LFSR_TAPS  = LFSR_TAPS_DEFAULT
) (
  input logic       clk,
  input logic       rst_n,
  inst_gen_if.master bus
);

  gen_state_e  state;
  logic [31:0] lfsr;
  logic [15:0] count;
  logic [15:0] num_q;
  logic [4:0]  class_en_q;
  logic        valid_q;
  logic        done_q;
  logic        handshake;
  logic [31:0] encoded;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  assign handshake = valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lfsr       <= LFSR_RESET;
      count      <= '0;
      num_q      <= '0;
      class_en_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.start) begin
          lfsr       <= (bus.seed == '0) ? LFSR_RESET : bus.seed;
          count      <= '0;
          num_q      <= bus.num_inst;
          class_en_q <= bus.class_en;
          if (bus.num_inst == '0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state   <= ST_RUN;
            valid_q <= 1'b1;
          end
        end
        ST_RUN: if (handshake) begin
          lfsr  <= lfsr_step(lfsr);
          count <= count + 16'd1;
          // Compare against count+1 so the last handshake ends RUN without ever wrapping count.
          if (count + 16'd1 == num_q) begin
            state   <= ST_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  inst_encode #(
    .NOP_OPCODE(NOP_OPCODE)
  ) u_encode (
    .lfsr       (lfsr),
    .class_en   (class_en_q),
    .instruction(encoded)
  );

  assign bus.out_valid   = valid_q;
  assign bus.busy        = valid_q;
  assign bus.done        = done_q;
  assign bus.instruction = valid_q ? encoded : '0;

endmodule

// File: tb/tb_inst_gen.sv
// Self-checking bench for inst_gen: queue-based word model plus directed scenarios.
module tb_inst_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_gen_if bus_i();

  inst_gen #(
    .NOP_OPCODE(7'b1111111),
    .LFSR_TAPS (32'h80200003)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_next(input logic [31:0] x);
    logic [31:0] r;
    r = x >> 1;
    if (x[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] l, input logic [4:0] cen);
    int unsigned cls, rd, rs1, rs2, f3, imm, f7;
    logic [31:0] w;
    cls = l[2:0];
    rd  = l[10:7];
    rs1 = l[18:15];
    rs2 = l[23:20];
    f3  = l[14:12];
    w   = 32'h7F;
    if (cls <= 3 && cen[cls]) begin
      case (cls)
        0: begin
          imm = l[31:20];
          if (f3 == 1) imm = imm % 32;
          if (f3 == 5) imm = (imm % 32) + (l[30] ? 32'h400 : 0);
          w = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end
        1: w = (int'(l[29:20]) << 20) | (2 << 12) | (rd << 7) | 32'h03;
        2: begin
          f7 = ((f3 == 0 || f3 == 5) && l[30]) ? 32 : 0;
          w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        end
        default: w = (int'(l[29:25]) << 25) | (rs2 << 20) | (2 << 12)
                     | (int'(l[11:7]) << 7) | 32'h23;
      endcase
    end
    return w;
  endfunction

  function automatic bit legal(input logic [31:0] w, input logic [4:0] cen);
    logic [6:0] op;
    op = w[6:0];
    case (op)
      7'h7F:   return w[31:7] == 25'h0;
      7'h13:   return cen[0] && !w[11] && !w[19];
      7'h03:   return cen[1] && !w[11] && w[19:15] == 5'h0 && w[31:30] == 2'b00 && w[14:12] == 3'b010;
      7'h33:   return cen[2] && !w[11] && !w[19] && !w[24];
      7'h23:   return cen[3] && !w[24] && w[19:15] == 5'h0 && w[31:30] == 2'b00 && w[14:12] == 3'b010;
      default: return 1'b0;
    endcase
  endfunction

  // phase: 0 idle, 1 emitting, 2 completion cycle
  int          ph = 0;
  logic [31:0] q[$];
  logic [4:0]  m_cen = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0;
      q.delete();
    end else begin
      case (ph)
        0: if (bus_i.start) begin
          logic [31:0] l;
          int n;
          l = (bus_i.seed == 0) ? 32'h1 : bus_i.seed;
          n = bus_i.num_inst;
          m_cen = bus_i.class_en;
          q.delete();
          for (int i = 0; i < n; i++) begin
            q.push_back(model_word(l, m_cen));
            l = model_next(l);
          end
          ph = (n == 0) ? 2 : 1;
        end
        1: if (bus_i.out_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  int hs_total = 0;
  always @(posedge clk)
    if (rst_n && bus_i.out_valid === 1'b1 && bus_i.out_ready === 1'b1) hs_total++;

  always @(negedge clk) begin
    chk("out_valid", {31'b0, bus_i.out_valid}, {31'b0, ph == 1});
    chk("busy", {31'b0, bus_i.busy}, {31'b0, ph == 1});
    chk("done", {31'b0, bus_i.done}, {31'b0, ph == 2});
    chk("instruction", bus_i.instruction, (ph == 1 && q.size() > 0) ? q[0] : 32'h0);
    if (ph == 1) chk("legal", {31'b0, legal(bus_i.instruction, m_cen)}, 32'h1);
  end

  // ---------------- directed stimulus ----------------
  task automatic start_seq(input logic [31:0] s, input logic [15:0] n, input logic [4:0] cen);
    @(negedge clk);
    bus_i.seed = s;
    bus_i.num_inst = n;
    bus_i.class_en = cen;
    bus_i.start = 1'b1;
    @(negedge clk);
    bus_i.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int i;
    for (i = 0; i < budget; i++) begin
      if (bus_i.done === 1'b1) break;
      @(negedge clk);
      if (rand_ready) bus_i.out_ready = 1'($urandom_range(0, 1));
    end
    if (i >= budget) begin
      errors++;
      $display("FAIL wait_done: got no done pulse expected done within %0d cycles", budget);
    end
    bus_i.out_ready = 1'b1;
  endtask

  initial begin
    int hs0;
    bus_i.start = 1'b0;
    bus_i.seed = '0;
    bus_i.num_inst = '0;
    bus_i.class_en = '0;
    bus_i.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_instr", bus_i.instruction, 32'h0);
    chk("rst_valid", {31'b0, bus_i.out_valid}, 32'h0);
    rst_n = 1'b1;

    // All classes disabled: NOP stream, done after the 4th handshake.
    bus_i.out_ready = 1'b1;
    start_seq(32'h1234, 16'd4, 5'b00000);
    for (int i = 0; i < 4; i++) begin
      chk("nop_word", bus_i.instruction, 32'h0000007F);
      @(negedge clk);
    end
    chk("nop_done", {31'b0, bus_i.done}, 32'h1);
    repeat (2) @(negedge clk);

    // Zero-length request.
    start_seq(32'h55, 16'd0, 5'b11111);
    chk("zero_done", {31'b0, bus_i.done}, 32'h1);
    chk("zero_valid", {31'b0, bus_i.out_valid}, 32'h0);
    repeat (2) @(negedge clk);

    // Seed 0 behaves as seed 1; first three words hand-derived.
    start_seq(32'h0, 16'd3, 5'b11111);
    chk("seed0_w0", bus_i.instruction, 32'h00002003);
    @(negedge clk);
    chk("seed0_w1", bus_i.instruction, 32'h00202023);
    @(negedge clk);
    chk("seed0_w2", bus_i.instruction, 32'h40300033);
    wait_done(20, 1'b0);
    start_seq(32'h1, 16'd1, 5'b11111);
    chk("seed1_w0", bus_i.instruction, 32'h00002003);
    wait_done(20, 1'b0);
    repeat (2) @(negedge clk);

    // Back-pressure stall with an ignored start while busy.
    start_seq(32'hDEADBEEF, 16'd10, 5'b11111);
    repeat (2) @(negedge clk);
    bus_i.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_i.start = (i == 1);
      bus_i.num_inst = 16'd0;
      chk("stall_valid", {31'b0, bus_i.out_valid}, 32'h1);
      @(negedge clk);
    end
    bus_i.start = 1'b0;
    bus_i.out_ready = 1'b1;
    wait_done(40, 1'b0);
    repeat (2) @(negedge clk);

    // Subset of classes enabled.
    start_seq(32'hA5A5F00F, 16'd50, 5'b00101);
    wait_done(100, 1'b0);
    repeat (2) @(negedge clk);

    // Reset mid-run after three handshakes.
    start_seq(32'h13579BDF, 16'd10, 5'b11111);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_valid", {31'b0, bus_i.out_valid}, 32'h0);
    chk("abort_done", {31'b0, bus_i.done}, 32'h0);
    chk("abort_instr", bus_i.instruction, 32'h0);
    repeat (3) @(negedge clk);

    // Long run with random back-pressure.
    hs0 = hs_total;
    start_seq(32'h0BADF00D, 16'd1000, 5'b11111);
    wait_done(20000, 1'b1);
    chk("hs_count", 32'(hs_total - hs0), 32'd1000);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_gen.md
INST_GEN -- requirements
Module: inst_gen

Interface
REQ-001: Parameter NOP_OPCODE, default 7'b1111111, opcode of the legal NOP class.
REQ-002: Parameter LFSR_TAPS, default 32'h80200003, Galois LFSR feedback mask.
REQ-003: clk  input  1  sole clock, all state on posedge.
REQ-004: rst_n  input  1  reset; synchronous, active-low.
REQ-005: start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-006: seed  input  32  LFSR seed, sampled on accepted start.
REQ-007: num_inst  input  16  instructions to emit, sampled on accepted start.
REQ-008: class_en  input  5  enables {NOP,SW,R,LW,I} (bit4..bit0), sampled on accepted start.
REQ-009: out_valid  output  1  instruction is valid.
REQ-010: out_ready  input  1  consumer accepts instruction.
REQ-011: instruction  output  32  generated RV32 instruction word.
REQ-012: busy  output  1  high in RUN.
REQ-013: done  output  1  one-cycle pulse when the sequence completes.

Function
REQ-014: FSM states IDLE, RUN, DONE; IDLE->RUN on start with num_inst!=0; IDLE->DONE on start with num_inst==0; RUN->DONE on the handshake that makes the accepted count equal num_inst; DONE->IDLE unconditionally next cycle.
REQ-015: On accepted start, LFSR loads seed, or 32'h00000001 when seed==0; counter clears.
REQ-016: out_valid is high exactly in RUN; first out_valid is the cycle after accepted start.
REQ-017: Handshake = out_valid && out_ready; LFSR advances one step and counter increments only on handshake.
REQ-018: instruction and out_valid remain stable while out_valid && !out_ready.
REQ-019: instruction is a pure function of the registered LFSR value and registered class_en; no combinational path from out_ready to instruction.
REQ-020: Class index = lfsr[2:0]: 0=I, 1=LW, 2=R, 3=SW, 4=NOP; index 5-7 or a disabled class yields NOP.
REQ-021: NOP: opcode=NOP_OPCODE, bits[31:7]=0.
REQ-022: All classes: rd, rs1, rs2 fields take bit4=0, bits[3:0] from lfsr[10:7], lfsr[18:15], lfsr[23:20].
REQ-023: I: opcode 0010011, funct3=lfsr[14:12]; funct3 001 forces imm[11:5]=0000000; funct3 101 forces imm[11:5]={0,lfsr[30],00000}; else imm12=lfsr[31:20].
REQ-024: LW: opcode 0000011, funct3 010, rs1=0, instruction[31:30]=00, imm[9:0]=lfsr[29:20].
REQ-025: R: opcode 0110011, funct3=lfsr[14:12]; funct7=0100000 if funct3 in {000,101} and lfsr[30]=1, else 0000000.
REQ-026: SW: opcode 0100011, funct3 010, rs1=0, instruction[31:30]=00, remaining imm bits from lfsr.
REQ-027: Every emitted word satisfies the team's instruction-legality constraint set for the enabled classes.
REQ-028: start while busy or in DONE is ignored; inputs not resampled.
REQ-029: num_inst=16'hFFFF emits 65535 instructions; counter never wraps.

Reset
REQ-030: rst_n=0 at a posedge forces IDLE; out_valid=0, busy=0, done=0, instruction=32'h0, LFSR=32'h1, counter=0, class_en register=0.
REQ-031: Reset mid-RUN aborts the sequence without a done pulse.

Structure
REQ-032: Shared package qed_isa_pkg holds opcode/funct3/funct7 constants, NOP_OPCODE default, class enum, and REG_LIMIT=16.
REQ-033: One combinational sub-module inst_encode maps (lfsr, class_en) to instruction; inst_gen holds FSM, LFSR, counter.

Verification
REQ-034: class_en=5'b00000, num_inst=4, out_ready=1 -> four words 32'h0000007F on consecutive cycles, done pulse cycle after 4th handshake.
REQ-035: num_inst=0, start -> done next cycle, out_valid never asserted, back to IDLE.
REQ-036: seed=0 -> first word equals that for seed=32'h00000001.
REQ-037: out_ready held low 5 cycles mid-run -> instruction and out_valid unchanged all 5 cycles.
REQ-038: class_en=5'b11111, num_inst=1000, random out_ready -> all words legal (regs<16, LW/SW rs1=0 and bits[31:30]=00), exactly 1000 handshakes.
REQ-039: rst_n low for 1 cycle after 3 handshakes -> IDLE outputs next cycle, no done pulse.
